// File: rtl/jhash_pkg.sv
// Shared definitions for the Jenkins-hash scheduler and engine: FSM encoding,
// the golden seed constant and the default job-length width.
package jhash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  localparam logic [31:0] JHASH_GOLDEN = 32'hdeadbeef;
  localparam int          JHASH_LENW   = 16;

endpackage

// File: rtl/jhash_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr_i,
// wrapping, returned both one-hot and encoded.
module jhash_rr_pick #(
  parameter int NCH = 4,
  localparam int PW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [PW-1:0]  ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [PW-1:0]  idx_o
);

  logic          found;
  logic [PW-1:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NCH; off++) begin
      cand = PW'((int'(ptr_i) + off) % NCH);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/jhash_sched.sv
// Round-robin scheduler sharing one Jenkins-hash engine among NCH channels,
// with a RUN watchdog and a valid/ready result port back to the granted channel.
module jhash_sched
  import jhash_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int LENW    = JHASH_LENW,
  parameter int TIMEOUT = 4096,
  localparam int PW     = $clog2(NCH),
  localparam int CW     = $clog2(TIMEOUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*LENW-1:0] ch_len,
  input  logic [NCH*32-1:0] ch_init,
  output logic [NCH-1:0]    ch_gnt,
  output logic              eng_start,
  output logic [LENW-1:0]   eng_len,
  output logic [31:0]       eng_init,
  output logic              eng_abort,
  input  logic              eng_done,
  input  logic [31:0]       eng_hash,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PW-1:0]     res_ch,
  output logic [31:0]       res_hash,
  output logic              res_err
);

  state_e          state_q;
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [NCH-1:0]  gnt_q;
  logic            start_q;
  logic            abort_q;
  logic [LENW-1:0] len_q;
  logic [31:0]     init_q;
  logic            valid_q;
  logic [PW-1:0]   ch_q;
  logic [31:0]     hash_q;
  logic            err_q;

  logic [NCH-1:0]  pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic [LENW-1:0] len_sel;
  logic [31:0]     init_sel;

  jhash_rr_pick #(.NCH(NCH)) u_pick (
    .req_i (ch_req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  // One-hot grant selects the winning channel's descriptor slices.
  always_comb begin
    len_sel  = '0;
    init_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pick_gnt[i]) begin
        len_sel  = ch_len[i*LENW +: LENW];
        init_sel = ch_init[i*32 +: 32];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(NCH - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      len_q   <= '0;
      init_q  <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      hash_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|ch_req) begin
            gnt_q  <= pick_gnt;
            ch_q   <= pick_idx;
            len_q  <= len_sel;
            init_q <= init_sel;
            if (len_sel == '0) begin
              // Zero-length job never touches the engine.
              hash_q  <= init_sel + JHASH_GOLDEN;
              err_q   <= 1'b0;
              valid_q <= 1'b1;
              state_q <= ST_RESULT;
            end else begin
              start_q <= 1'b1;
              state_q <= ST_START;
            end
          end
        end
        ST_START: begin
          cnt_q   <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (eng_done) begin
            hash_q  <= eng_hash;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ST_RESULT;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            abort_q <= 1'b1;
            hash_q  <= '0;
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state_q <= ST_RESULT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            valid_q <= 1'b0;
            gnt_q   <= '0;
            ptr_q   <= ch_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ch_gnt    = gnt_q;
  assign eng_start = start_q;
  assign eng_len   = len_q;
  assign eng_init  = init_q;
  assign eng_abort = abort_q;
  assign res_valid = valid_q;
  assign res_ch    = ch_q;
  assign res_hash  = hash_q;
  assign res_err   = err_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_start_state: assert property (@(posedge clk) disable iff (!rst_n) start_q |-> state_q == ST_START);
  a_abort_err:   assert property (@(posedge clk) disable iff (!rst_n) abort_q |-> (state_q == ST_RESULT && err_q));
  a_valid_state: assert property (@(posedge clk) disable iff (!rst_n) valid_q == (state_q == ST_RESULT));

endmodule
